// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// Serial receive front-end of the UART peripheral. Recovers 8N1 frames
// (LSB first, idle-high line) from the raw RX pin. Each bit is sampled at
// its middle, and a start bit that does not last until its midpoint is
// rejected as a glitch.
//
// Ports
//   clk       in   system clock; everything runs on the rising edge
//   rst       in   synchronous, active-high reset
//   rx_en     in   receiver enable; dropping it aborts any frame in flight
//   data_in   in   asynchronous serial RX line
//   data_out  out  last received byte; held until the next completed frame
//   done      out  one-cycle pulse when a frame completes
//   err       out  framing error (stop bit low) of the last completed frame
//   busy      out  high whenever the receiver is not in IDLE
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle; waiting for a falling edge while enabled
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits, one per bit period
// STOP  | timing to the middle of the stop bit; publishes the byte
// BREAK | stop bit was low; waiting for the line to return high
//
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_en,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       done,
   output logic       err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic             sync1;
   logic             rxs;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic [7:0]       data_out_nxt;
   logic             done_nxt;
   logic             err_nxt;

   // Two-flop synchronizer; both stages reset to the idle (high) level so a
   // low line during reset cannot look like a start bit afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= data_in;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         data_out <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
         data_out <= data_out_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      data_out_nxt = data_out;
      done_nxt     = 1'b0;
      err_nxt      = err;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (rx_en && !rxs) begin
               state_nxt = START;
            end
         end

         START: begin
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (!rxs) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end else begin
                  // Line went back high before mid start bit: glitch.
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt     = '0;
               // Right shift with the new bit at the top: after 8 samples
               // the first (LSB) bit has reached bit 0.
               shift_nxt   = {rxs, shift[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_nxt      = '0;
               data_out_nxt = shift;
               done_nxt     = 1'b1;
               err_nxt      = ~rxs;
               // A low stop bit means the line may be held in break; park
               // until it recovers so it cannot retrigger frames.
               state_nxt    = rxs ? IDLE : BREAK;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         BREAK: begin
            cnt_nxt = '0;
            if (rxs) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Disabling the receiver abandons the frame without publishing it.
      if (!rx_en && (state != IDLE)) begin
         state_nxt    = IDLE;
         cnt_nxt      = '0;
         data_out_nxt = data_out;
         done_nxt     = 1'b0;
         err_nxt      = err;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       done;
   logic       err;
   logic       busy;

   uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_en    (rx_en),
      .data_in  (data_in),
      .data_out (data_out),
      .done     (done),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t sb_q[$];

   int pass_cnt      = 0;
   int total_cnt     = 0;
   int done_cnt      = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;
   int start_cyc     = 0;
   int first_cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total_cnt++;
      if (act >= lo && act <= hi) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   // Monitor: every done pulse must match the next expected frame.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         done_cnt++;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         check("done_expected", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rx_byte", 32'(data_out), 32'(e.d));
            check("rx_err", 32'(err), 32'(e.e));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v);
      data_in = v;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_v);
   endtask

   initial begin
      // Reset with the line low.
      rst = 1'b1; rx_en = 1'b0; data_in = 1'b0;
      tick(3);
      check("rst_data_out", 32'(data_out), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0; data_in = 1'b1; rx_en = 1'b1;
      tick(200);
      check("idle_done_cnt", done_cnt, 0);
      check("idle_busy", 32'(busy), 0);

      // Single frame 0xA5.
      sb_q.push_back('{d: 8'hA5, e: 1'b0});
      send_frame(8'hA5, 1'b1);
      check("a5_done_cnt", done_cnt, 1);
      check_range("a5_latency", last_done_cyc - start_cyc, 154, 156);
      check("a5_busy_after", 32'(busy), 0);

      // Back-to-back 0x00 then 0xFF with no idle gap.
      sb_q.push_back('{d: 8'h00, e: 1'b0});
      sb_q.push_back('{d: 8'hFF, e: 1'b0});
      send_frame(8'h00, 1'b1);
      first_cyc = start_cyc;
      send_frame(8'hFF, 1'b1);
      check("b2b_done_cnt", done_cnt, 3);
      check("b2b_spacing", last_done_cyc - prev_done_cyc, 160);

      // Start-bit glitch.
      data_in = 1'b0;
      tick(4);
      check("glitch_busy_high", 32'(busy), 1);
      data_in = 1'b1;
      tick(20);
      check("glitch_busy_low", 32'(busy), 0);
      check("glitch_done_cnt", done_cnt, 3);
      check("glitch_data_out", 32'(data_out), 32'hFF);
      check("glitch_err", 32'(err), 0);

      // Framing error then break: stop bit low, line low 60 cycles after data.
      sb_q.push_back('{d: 8'h3C, e: 1'b1});
      send_frame(8'h3C, 1'b0);
      data_in = 1'b0;
      tick(60 - CPB);
      check("break_done_cnt", done_cnt, 4);
      check("break_busy", 32'(busy), 1);
      data_in = 1'b1;
      tick(20);
      check("break_exit_busy", 32'(busy), 0);
      check("break_exit_done_cnt", done_cnt, 4);
      sb_q.push_back('{d: 8'h55, e: 1'b0});
      send_frame(8'h55, 1'b1);
      check("good_after_break_cnt", done_cnt, 5);
      check("good_after_break_err", 32'(err), 0);

      // rx_en dropped in the middle of data bit 3 of 0x81.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      data_in = 1'b0;
      tick(CPB / 2);
      rx_en = 1'b0;
      tick(3);
      check("abort_busy", 32'(busy), 0);
      tick(CPB / 2 - 3);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      check("abort_done_cnt", done_cnt, 5);
      check("abort_data_out", 32'(data_out), 32'h55);
      check("abort_err", 32'(err), 0);

      // Whole frame while disabled is ignored.
      send_frame(8'h81, 1'b1);
      check("disabled_done_cnt", done_cnt, 5);
      check("disabled_busy", 32'(busy), 0);
      rx_en = 1'b1;
      tick(10);

      // Reset in the middle of a frame.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      check("midframe_busy_before", 32'(busy), 1);
      rst = 1'b1;
      tick(1);
      check("midrst_data_out", 32'(data_out), 0);
      check("midrst_err", 32'(err), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_busy", 32'(busy), 0);
      data_in = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(200);
      check("midrst_done_cnt", done_cnt, 5);
      check("midrst_busy_after", 32'(busy), 0);

      check("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
